// File: rtl/maze_pkg.sv
// ============================================================================
//  Module      : maze_pkg
//  Description : Shared state encoding, default constants and widths for the
//                maze game round sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package maze_pkg;

    localparam int DEF_NUM_LEVELS    = 4;
    localparam int DEF_LIVES         = 3;
    localparam int DEF_TIME_LIMIT    = 60;
    localparam int DEF_TICKS_PER_SEC = 60;
    localparam int DEF_HOLD_FRAMES   = 120;
    localparam int DEF_ARM_CYCLES    = 2;

    localparam int SECS_W  = 7;
    localparam int LIVES_W = 2;
    localparam int SCORE_W = 16;

    localparam logic [2:0] ENC_IDLE      = 3'd0;
    localparam logic [2:0] ENC_ARM       = 3'd1;
    localparam logic [2:0] ENC_PLAY      = 3'd2;
    localparam logic [2:0] ENC_WIN_HOLD  = 3'd3;
    localparam logic [2:0] ENC_LOSE_HOLD = 3'd4;
    localparam logic [2:0] ENC_DONE      = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = ENC_IDLE,
        ST_ARM       = ENC_ARM,
        ST_PLAY      = ENC_PLAY,
        ST_WIN_HOLD  = ENC_WIN_HOLD,
        ST_LOSE_HOLD = ENC_LOSE_HOLD,
        ST_DONE      = ENC_DONE
    } state_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/maze_countdown.sv
// ============================================================================
//  Module      : maze_countdown
//  Description : Frame-tick divider and per-level seconds down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_countdown
    import maze_pkg::*;
#(
    parameter int TIME_LIMIT    = DEF_TIME_LIMIT,
    parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tick_i,
    input  logic              load_i,
    input  logic              en_i,
    output logic [SECS_W-1:0] secs_o,
    output logic              expired_o
);

    localparam int              DIV_W     = cnt_width(TICKS_PER_SEC);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICKS_PER_SEC - 1);
    localparam logic [SECS_W-1:0] SECS_INIT = SECS_W'(TIME_LIMIT);

    logic [DIV_W-1:0]  div_q,  div_d;
    logic [SECS_W-1:0] secs_q, secs_d;
    logic              expired;

    // expired is a combinational pulse so the sequencer leaves PLAY on the
    // same edge the seconds counter lands on zero.
    always_comb begin
        div_d   = div_q;
        secs_d  = secs_q;
        expired = 1'b0;
        if (load_i) begin
            div_d  = '0;
            secs_d = SECS_INIT;
        end else if (en_i && tick_i) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (secs_q <= SECS_W'(1)) begin
                    secs_d  = '0;
                    expired = 1'b1;
                end else begin
                    secs_d = secs_q - SECS_W'(1);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            secs_q <= SECS_INIT;
        end else begin
            div_q  <= div_d;
            secs_q <= secs_d;
        end
    end

    assign secs_o    = secs_q;
    assign expired_o = expired;

endmodule

`default_nettype wire

// File: rtl/maze_game_ctrl.sv
// ============================================================================
//  Module      : maze_game_ctrl
//  Description : Round sequencer for the maze game (level, lives, countdown,
//                banners). Optional macro MAZE_SCORE_EN adds a score output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int NUM_LEVELS    = DEF_NUM_LEVELS,
    parameter int LIVES         = DEF_LIVES,
    parameter int TIME_LIMIT    = DEF_TIME_LIMIT,
    parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int HOLD_FRAMES   = DEF_HOLD_FRAMES,
    parameter int ARM_CYCLES    = DEF_ARM_CYCLES
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          frame_tick_i,
    input  logic                          start_i,
    input  logic                          col_win_i,
    input  logic                          col_over_i,
    output logic                          col_rst_o,
    output logic                          play_en_o,
    output logic [$clog2(NUM_LEVELS)-1:0] level_o,
    output logic [LIVES_W-1:0]            lives_left_o,
    output logic [SECS_W-1:0]             secs_left_o,
    output logic                          show_win_o,
    output logic                          show_lose_o,
`ifdef MAZE_SCORE_EN
    output logic [SCORE_W-1:0]            score_o,
`endif
    output logic                          game_done_o
);

    localparam int                 LVL_W     = $clog2(NUM_LEVELS);
    localparam int                 HOLD_W    = cnt_width(HOLD_FRAMES);
    localparam int                 ARM_W     = cnt_width(ARM_CYCLES);
    localparam logic [LVL_W-1:0]   LVL_LAST  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [ARM_W-1:0]   ARM_LAST  = ARM_W'(ARM_CYCLES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    state_t               state_q, state_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [ARM_W-1:0]     arm_cnt_q, arm_cnt_d;
    logic                 first_q, first_d;
    logic                 col_rst_q, play_en_q, show_win_q, show_lose_q, game_done_q;

    logic [SECS_W-1:0]    secs;
    logic                 expired;
    logic                 flag_win, flag_over;

    maze_countdown #(
        .TIME_LIMIT    (TIME_LIMIT),
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_countdown (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .tick_i    (frame_tick_i),
        .load_i    (state_q == ST_ARM),
        .en_i      (state_q == ST_PLAY),
        .secs_o    (secs),
        .expired_o (expired)
    );

    // The checker's flags trail its reset by a clock, so the first PLAY
    // cycle still carries stale values from the previous round.
    assign flag_win  = col_win_i  && !first_q;
    assign flag_over = col_over_i && !first_q;

    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        lives_d    = lives_q;
        hold_cnt_d = hold_cnt_q;
        arm_cnt_d  = arm_cnt_q;
        first_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (arm_cnt_q == ARM_LAST) begin
                    state_d = ST_PLAY;
                    first_d = 1'b1;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            ST_PLAY: begin
                if (flag_win) begin
                    state_d = ST_WIN_HOLD;
                end else if (flag_over || expired) begin
                    state_d = ST_LOSE_HOLD;
                    lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
                end
            end
            ST_WIN_HOLD: begin
                if (frame_tick_i) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_ARM;
                        level_d = (level_q == LVL_LAST) ? '0 : level_q + LVL_W'(1);
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            ST_LOSE_HOLD: begin
                if (frame_tick_i) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = (lives_q == '0) ? ST_DONE : ST_ARM;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    state_d = ST_ARM;
                    lives_d = LIVES_INIT;
                    level_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Entering any state restarts its counters; a tick on the entry edge
        // is therefore never counted.
        if (state_d != state_q) begin
            hold_cnt_d = '0;
            arm_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            lives_q     <= LIVES_INIT;
            hold_cnt_q  <= '0;
            arm_cnt_q   <= '0;
            first_q     <= 1'b0;
            col_rst_q   <= 1'b1;
            play_en_q   <= 1'b0;
            show_win_q  <= 1'b0;
            show_lose_q <= 1'b0;
            game_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            lives_q     <= lives_d;
            hold_cnt_q  <= hold_cnt_d;
            arm_cnt_q   <= arm_cnt_d;
            first_q     <= first_d;
            col_rst_q   <= (state_d == ST_IDLE) || (state_d == ST_ARM) || (state_d == ST_DONE);
            play_en_q   <= (state_d == ST_PLAY);
            show_win_q  <= (state_d == ST_WIN_HOLD);
            show_lose_q <= (state_d == ST_LOSE_HOLD);
            game_done_q <= (state_d == ST_DONE);
        end
    end

`ifdef MAZE_SCORE_EN
    logic [SCORE_W-1:0] score_q, score_d;
    logic [31:0]        win_pts, score_sum;

    always_comb begin
        win_pts   = 32'(secs) * (32'(level_q) + 32'd1);
        score_sum = 32'(score_q) + win_pts;
        score_d   = score_q;
        if (state_q == ST_PLAY && state_d == ST_WIN_HOLD) begin
            score_d = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[SCORE_W-1:0];
        end else if (state_q == ST_DONE && state_d == ST_ARM) begin
            score_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) score_q <= '0;
        else         score_q <= score_d;
    end

    assign score_o = score_q;
`endif

    assign col_rst_o    = col_rst_q;
    assign play_en_o    = play_en_q;
    assign level_o      = level_q;
    assign lives_left_o = lives_q;
    assign secs_left_o  = secs;
    assign show_win_o   = show_win_q;
    assign show_lose_o  = show_lose_q;
    assign game_done_o  = game_done_q;

endmodule

`default_nettype wire

// File: tb/tb_maze_game_ctrl.sv
// ============================================================================
//  Module      : tb_maze_game_ctrl
//  Description : Scoreboard bench for maze_game_ctrl with default parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_maze_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, start = 1'b0, col_win = 1'b0, col_over = 1'b0;
    logic       col_rst, play_en, show_win, show_lose, game_done;
    logic [1:0] level, lives;
    logic [6:0] secs;
`ifdef MAZE_SCORE_EN
    logic [15:0] score;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int m_level  = 0;
    int m_lives  = 3;
    int m_score  = 0;

    typedef struct {
        string tag;
        int col_rst, play_en, show_win, show_lose, game_done;
        int level, lives, secs, score;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    maze_game_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .frame_tick_i (frame_tick),
        .start_i      (start),
        .col_win_i    (col_win),
        .col_over_i   (col_over),
        .col_rst_o    (col_rst),
        .play_en_o    (play_en),
        .level_o      (level),
        .lives_left_o (lives),
        .secs_left_o  (secs),
        .show_win_o   (show_win),
        .show_lose_o  (show_lose),
`ifdef MAZE_SCORE_EN
        .score_o      (score),
`endif
        .game_done_o  (game_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int cr, input int pe, input int sw,
                        input int sl, input int gd, input int s);
        exp_t e;
        e.tag = tag; e.col_rst = cr; e.play_en = pe; e.show_win = sw;
        e.show_lose = sl; e.game_done = gd; e.secs = s;
        e.level = m_level; e.lives = m_lives; e.score = m_score;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk({e.tag, ".col_rst"},   col_rst,   e.col_rst);
        chk({e.tag, ".play_en"},   play_en,   e.play_en);
        chk({e.tag, ".show_win"},  show_win,  e.show_win);
        chk({e.tag, ".show_lose"}, show_lose, e.show_lose);
        chk({e.tag, ".game_done"}, game_done, e.game_done);
        chk({e.tag, ".level"},     level,     e.level);
        chk({e.tag, ".lives"},     lives,     e.lives);
        if (e.secs >= 0) chk({e.tag, ".secs"}, secs, e.secs);
`ifdef MAZE_SCORE_EN
        chk({e.tag, ".score"}, score, e.score);
`endif
    endtask

    task automatic frames(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) cyc();
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
        end
    endtask

    task automatic score_win(input int s);
        m_score = m_score + s * (m_level + 1);
        if (m_score > 65535) m_score = 65535;
    endtask

    task automatic to_play();
        push("arm2", 1, 0, 0, 0, 0, 60); cyc(); sb_check();
        push("play", 0, 1, 0, 0, 0, 60); cyc(); sb_check();
    endtask

    task automatic finish_win(input int gap);
        push("win_hold", 0, 0, 1, 0, 0, -1); frames(119, gap); sb_check();
        m_level = (m_level + 1) % 4;
        push("win_arm", 1, 0, 0, 0, 0, -1); frames(1, gap); sb_check();
    endtask

    task automatic finish_lose();
        push("lose_hold", 0, 0, 0, 1, 0, -1); frames(119, 0); sb_check();
        if (m_lives == 0) push("done", 1, 0, 0, 0, 1, -1);
        else              push("lose_arm", 1, 0, 0, 0, 0, -1);
        frames(1, 0); sb_check();
    endtask

    task automatic win_now();
        cyc();
        col_win = 1'b1;
        score_win(60);
        push("win", 0, 0, 1, 0, 0, 60); cyc(); sb_check();
        col_win = 1'b0;
    endtask

    task automatic lose_now();
        cyc();
        col_over = 1'b1;
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        push("over", 0, 0, 0, 1, 0, -1); cyc(); sb_check();
        col_over = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) cyc();
        push("reset", 1, 0, 0, 0, 0, 60); sb_check();
        rst_n = 1'b1;
        push("idle", 1, 0, 0, 0, 0, 60); cyc(); sb_check();

        start = 1'b1;
        push("arm1", 1, 0, 0, 0, 0, 60); cyc(); sb_check();
        start = 1'b0;
        to_play();

        // Flags during the first PLAY cycle must be ignored.
        col_win = 1'b1; col_over = 1'b1;
        push("first_ignored", 0, 1, 0, 0, 0, 60); cyc(); sb_check();
        col_win = 1'b0; col_over = 1'b0;

        // Win with a frame tick on the entry edge, sparse ticks during hold.
        col_win = 1'b1; frame_tick = 1'b1;
        score_win(60);
        push("win_entry", 0, 0, 1, 0, 0, 60); cyc(); sb_check();
        col_win = 1'b0; frame_tick = 1'b0;
        finish_win(1);
        to_play();

        // Simultaneous win and game-over: win has priority.
        cyc();
        col_win = 1'b1; col_over = 1'b1;
        score_win(60);
        push("win_and_over", 0, 0, 1, 0, 0, 60); cyc(); sb_check();
        col_win = 1'b0; col_over = 1'b0;
        finish_win(0);
        to_play();

        // Timeout at level 2.
        push("secs_one", 0, 1, 0, 0, 0, 1); frames(3599, 0); sb_check();
        m_lives = m_lives - 1;
        push("timeout", 0, 0, 0, 1, 0, 0); frames(1, 0); sb_check();
        start = 1'b1;
        finish_lose();
        start = 1'b0;
        to_play();

        lose_now(); finish_lose(); to_play();
        lose_now(); finish_lose();
        push("done_stay", 1, 0, 0, 0, 1, -1); cyc(); sb_check();

        start = 1'b1;
        m_lives = 3; m_level = 0; m_score = 0;
        push("restart", 1, 0, 0, 0, 0, -1); cyc(); sb_check();
        start = 1'b0;
        to_play();

        // Four wins walk the level index through its wrap.
        for (int i = 0; i < 4; i++) begin
            win_now(); finish_win(0); to_play();
        end

        lose_now(); finish_lose(); to_play();
        win_now(); finish_win(0); to_play();

        push("secs_37", 0, 1, 0, 0, 0, 37); frames(1380, 0); sb_check();
        #2;
        rst_n = 1'b0;
        #1;
        m_level = 0; m_lives = 3; m_score = 0;
        push("async_rst", 1, 0, 0, 0, 0, 60); sb_check();
        push("post_rst", 1, 0, 0, 0, 0, 60);
        cyc(); rst_n = 1'b1; cyc(); sb_check();

        chk("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/maze_game_ctrl.md
Name: maze_game_ctrl

Overview:
- Top-level round sequencer for the maze game; sits above the collision checker.
- Drives the collision checker's active-high reset and consumes its registered win / game_over flags.
- Tracks level, lives and a per-level countdown; generates hold periods for the win/lose screens.
- Outputs feed the renderer (maze select, banners) and player-movement enable.

Parameters:
- NUM_LEVELS, 4, number of mazes; level index wraps to 0 after the last is cleared
- LIVES, 3, lives at game start
- TIME_LIMIT, 60, seconds per level attempt
- TICKS_PER_SEC, 60, frame_tick pulses per second
- HOLD_FRAMES, 120, frame_tick pulses the win/lose banner is held
- ARM_CYCLES, 2, clk cycles col_rst is held high before play

Ports:
- clk  in  1  system/pixel clock
- rst  in  1  asynchronous, active-low reset; all state clears immediately on assertion
- frame_tick  in  1  one-clk pulse per frame (vsync edge)
- start  in  1  debounced start button, level-sensitive
- col_win  in  1  win flag from the collision checker
- col_over  in  1  game_over flag from the collision checker
- col_rst  out  1  active-high reset to the collision checker
- play_en  out  1  player movement enable
- level  out  $clog2(NUM_LEVELS)  current maze index
- lives_left  out  2  remaining lives
- secs_left  out  7  countdown seconds remaining
- show_win  out  1  level-cleared banner
- show_lose  out  1  life-lost banner
- game_done  out  1  all lives exhausted

Behaviour:
- Reset values: state=IDLE, col_rst=1, play_en=0, level=0, lives_left=LIVES, secs_left=TIME_LIMIT, show_win=0, show_lose=0, game_done=0, sub-counters=0.
- All outputs are registered; state transitions take effect on the next clk edge.
- IDLE: col_rst=1. When start=1, go to ARM.
- ARM: col_rst=1 for exactly ARM_CYCLES clks; secs_left and the tick divider reload. Then go to PLAY.
  - col_win / col_over are ignored in ARM and during the first PLAY cycle, because the checker's flags lag its reset by 1 clk.
- PLAY: col_rst=0, play_en=1. The tick divider counts frame_tick; at TICKS_PER_SEC ticks, secs_left decrements.
  - Event priority within one cycle: col_win > col_over > timeout (secs_left==0 at a second boundary).
  - col_win: go to WIN_HOLD.
  - col_over or timeout: go to LOSE_HOLD and decrement lives_left, saturating at 0.
- WIN_HOLD: play_en=0, show_win=1, col_rst=0 (banner stays latched). After HOLD_FRAMES frame_ticks:
  - level increments, wrapping from NUM_LEVELS-1 to 0;
  - go to ARM.
- LOSE_HOLD: play_en=0, show_lose=1. After HOLD_FRAMES frame_ticks:
  - lives_left==0: go to DONE;
  - otherwise: go to ARM, same level.
- DONE: game_done=1, col_rst=1, play_en=0. When start=1: reload lives_left=LIVES and level=0, then go to ARM.
- Hold counter counts only frame_tick pulses. frame_tick coincident with a state entry is not counted.
- start held high through a banner has no effect; start is sampled only in IDLE and DONE.
- Asynchronous reset mid-PLAY or mid-hold returns everything to the reset values on the same edge.

Optional Feature:
- Macro: MAZE_SCORE_EN.
- Defined: adds output score (16 bits, reset 0). On entry to WIN_HOLD, score += secs_left*(level+1), saturating at 16'hFFFF. Score clears when leaving DONE.
- Undefined: no score port and no score logic.

Decomposition:
- Package maze_pkg:
  - state encoding localparams (IDLE, ARM, PLAY, WIN_HOLD, LOSE_HOLD, DONE);
  - default constants for LIVES, TIME_LIMIT, TICKS_PER_SEC;
  - secs_left width.
- Sub-module maze_countdown: frame_tick divider plus seconds down-counter, with inputs load and en and outputs secs and expired pulse.
- The FSM stays in maze_game_ctrl.

Test Plan:
- Reset then start=1 for 1 clk -> col_rst high exactly 2 clks, then play_en=1, level=0, lives_left=3, secs_left=60.
- In PLAY, pulse col_win -> show_win=1 next clk; after 120 frame_ticks level=1, col_rst 2-clk pulse, secs_left=60.
- col_win and col_over high in the same cycle -> WIN_HOLD taken, lives_left unchanged.
- No events for 60*60 frame_ticks -> secs_left reaches 0, LOSE_HOLD, lives_left 3->2, same level replayed.
- Three losses -> game_done=1 after the final hold; start -> lives_left=3, level=0, ARM.
- Assert rst mid-PLAY at secs_left=37 -> immediately IDLE, col_rst=1, secs_left=60; with MAZE_SCORE_EN defined, win at level 2 with secs_left=40 -> score=120.
